// File: rtl/frv_mem_responder_pkg.sv
// Shared types and helpers for the memory-bus responder: bus widths, the
// wait-state LFSR step and the wait-target clamp.
package frv_mem_responder_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned XL     = XLEN - 1;
  localparam int unsigned STRB_W = XLEN / 8;

  typedef logic [XL:0]       word_t;
  typedef logic [STRB_W-1:0] strb_t;
  typedef logic [15:0]       lfsr_t;
  typedef logic [3:0]        wait_t;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1.
  function automatic lfsr_t lfsr_step(lfsr_t s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic wait_t wait_clamp(wait_t v, wait_t lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/frv_mem_responder_ram.sv
// Word-wide synchronous RAM with per-byte write enables, one-cycle registered
// read and write-first behaviour when reading and writing the same word.
module frv_mem_responder_ram
  import frv_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_W = 10
) (
  input  logic               g_clk,
  input  logic               g_resetn,
  input  logic               re,
  input  logic               we,
  input  logic [DEPTH_W-1:0] addr,
  input  logic [STRB_W-1:0]  strb,
  input  logic [XL:0]        wdata,
  output logic [XL:0]        rdata
);

  localparam int unsigned Words = 1 << DEPTH_W;

  word_t mem [Words];
  word_t merged;
  word_t rdata_q;

  always_ff @(posedge g_clk) begin
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (we && strb[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    merged = mem[addr];
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (we && strb[i]) begin
        merged[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= merged;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/frv_mem_responder.sv
// Memory-side end of the cen/wen/stall/strb bus: wait-state generation, address
// range check and response registers around a byte-writable RAM.
module frv_mem_responder
  import frv_mem_responder_pkg::*;
#(
  parameter logic [31:0] MEM_BASE    = 32'h8000_0000,
  parameter int unsigned MEM_DEPTH_W = 10,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter bit          RAND_STALL  = 1'b0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              mem_cen,
  input  logic              mem_wen,
  input  logic [STRB_W-1:0] mem_strb,
  input  logic [XL:0]       mem_addr,
  input  logic [XL:0]       mem_wdata,
  output logic              mem_stall,
  output logic              mem_error,
  output logic [XL:0]       mem_rdata
);

  localparam wait_t       WaitMax   = wait_t'(WAIT_CYCLES);
  localparam wait_t       TargetRst = RAND_STALL ? wait_clamp(LFSR_SEED[3:0], WaitMax) : WaitMax;
  localparam logic [29:0] BaseW     = MEM_BASE[31:2];

  wait_t wcnt_q, wcnt_d;
  wait_t wtarget_q, wtarget_d;
  lfsr_t lfsr_q, lfsr_d;
  logic  err_q, err_d;
  logic  zero_q, zero_d;

  logic                   accept;
  logic                   in_range;
  logic [29:0]            word_off;
  logic [MEM_DEPTH_W-1:0] index;
  word_t                  ram_rdata;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^mem_addr[1:0];

  assign word_off = mem_addr[XL:2] - BaseW;
  assign in_range = (mem_addr[XL:2] >= BaseW) && ((word_off >> MEM_DEPTH_W) == '0);
  assign index    = word_off[MEM_DEPTH_W-1:0];

  assign mem_stall = mem_cen && (wcnt_q != wtarget_q);
  assign accept    = mem_cen && !mem_stall;

  always_comb begin
    wcnt_d    = wcnt_q;
    wtarget_d = wtarget_q;
    lfsr_d    = lfsr_q;
    err_d     = err_q;
    zero_d    = zero_q;
    if (accept) begin
      wcnt_d = '0;
      lfsr_d = lfsr_step(lfsr_q);
      if (RAND_STALL) begin
        wtarget_d = wait_clamp(lfsr_d[3:0], WaitMax);
      end
      err_d = !in_range;
      // Error responses force rdata to zero; in-range writes leave it as is.
      if (!in_range) begin
        zero_d = 1'b1;
      end else if (!mem_wen) begin
        zero_d = 1'b0;
      end
    end else if (mem_cen) begin
      wcnt_d = wcnt_q + 4'd1;
    end else begin
      wcnt_d = '0;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      wcnt_q    <= '0;
      wtarget_q <= TargetRst;
      lfsr_q    <= LFSR_SEED;
      err_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      wcnt_q    <= wcnt_d;
      wtarget_q <= wtarget_d;
      lfsr_q    <= lfsr_d;
      err_q     <= err_d;
      zero_q    <= zero_d;
    end
  end

  frv_mem_responder_ram #(
    .DEPTH_W (MEM_DEPTH_W)
  ) u_ram (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .re       (accept && !mem_wen && in_range),
    .we       (accept && mem_wen && in_range),
    .addr     (index),
    .strb     (mem_strb),
    .wdata    (mem_wdata),
    .rdata    (ram_rdata)
  );

  assign mem_error = err_q;
  assign mem_rdata = zero_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_frv_mem_responder.sv
// Directed bench for frv_mem_responder: three instances (no wait, fixed wait
// of 3, random wait up to 15) sharing one request bus with separate cen lines.
module tb_frv_mem_responder;

  logic        clk;
  logic        rst_n;
  logic [2:0]  cen;
  logic        wen;
  logic [3:0]  strb;
  logic [31:0] addr;
  logic [31:0] wdata;
  wire  [2:0]  stall;
  wire  [2:0]  err;
  wire  [31:0] rdata [3];

  int n_cmp;
  int n_bad;
  int acc_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  frv_mem_responder #(
    .WAIT_CYCLES (0)
  ) u_w0 (
    .g_clk (clk), .g_resetn (rst_n), .mem_cen (cen[0]), .mem_wen (wen),
    .mem_strb (strb), .mem_addr (addr), .mem_wdata (wdata),
    .mem_stall (stall[0]), .mem_error (err[0]), .mem_rdata (rdata[0])
  );

  frv_mem_responder #(
    .WAIT_CYCLES (3)
  ) u_w3 (
    .g_clk (clk), .g_resetn (rst_n), .mem_cen (cen[1]), .mem_wen (wen),
    .mem_strb (strb), .mem_addr (addr), .mem_wdata (wdata),
    .mem_stall (stall[1]), .mem_error (err[1]), .mem_rdata (rdata[1])
  );

  frv_mem_responder #(
    .WAIT_CYCLES (15),
    .RAND_STALL  (1'b1)
  ) u_rnd (
    .g_clk (clk), .g_resetn (rst_n), .mem_cen (cen[2]), .mem_wen (wen),
    .mem_strb (strb), .mem_addr (addr), .mem_wdata (wdata),
    .mem_stall (stall[2]), .mem_error (err[2]), .mem_rdata (rdata[2])
  );

  // Independent acceptance counter for the random instance.
  always @(posedge clk) begin
    if (rst_n && cen[2] && !stall[2]) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request on instance s, return stall cycles seen; ends one
  // negedge after acceptance with cen dropped and the response visible.
  task automatic req(input int s, input logic w, input logic [3:0] sb,
                     input logic [31:0] a, input logic [31:0] d, output int ns);
    @(negedge clk);
    wen = w; strb = sb; addr = a; wdata = d; cen[s] = 1'b1; ns = 0;
    #1;
    while (stall[s] && ns < 40) begin
      @(negedge clk);
      #1;
      ns++;
    end
    @(negedge clk);
    cen[s] = 1'b0;
    #1;
  endtask

  // Reference LFSR written as a tap-mask parity.
  function automatic logic [15:0] ref_lfsr(input logic [15:0] l);
    return {^(l & 16'h002D), l[15:1]};
  endfunction

  initial begin
    int ns;
    logic [15:0] lf;
    logic [3:0]  tgt;
    logic [31:0] shadow [16];
    int          start_acc;

    n_cmp = 0; n_bad = 0; acc_cnt = 0;
    cen = '0; wen = 1'b0; strb = '0; addr = '0; wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_err0", {31'b0, err[0]}, 32'd0);
    chk("rst_rdata0", rdata[0], 32'd0);
    chk("rst_stall1", {31'b0, stall[1]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_stall0", {31'b0, stall[0]}, 32'd0);
    chk("rel_err1", {31'b0, err[1]}, 32'd0);
    chk("rel_rdata1", rdata[1], 32'd0);

    // No-wait instance: basic write/read, strobes, no-op strobe.
    req(0, 1'b1, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF, ns);
    chk("w0_wr_stall", 32'(ns), 32'd0);
    chk("w0_wr_rdata_held", rdata[0], 32'd0);
    req(0, 1'b0, 4'h0, 32'h8000_0010, 32'h0, ns);
    chk("w0_rd_stall", 32'(ns), 32'd0);
    chk("w0_rd_data", rdata[0], 32'hDEAD_BEEF);
    chk("w0_rd_err", {31'b0, err[0]}, 32'd0);
    req(0, 1'b1, 4'hF, 32'h8000_0020, 32'hFFFF_FFFF, ns);
    req(0, 1'b1, 4'b0101, 32'h8000_0020, 32'h1122_3344, ns);
    chk("strb_rdata_held", rdata[0], 32'hDEAD_BEEF);
    req(0, 1'b0, 4'h0, 32'h8000_0020, 32'h0, ns);
    chk("strb_merge", rdata[0], 32'hFF22_FF44);
    req(0, 1'b1, 4'h0, 32'h8000_0010, 32'h0, ns);
    req(0, 1'b0, 4'h0, 32'h8000_0010, 32'h0, ns);
    chk("strb0_noop", rdata[0], 32'hDEAD_BEEF);

    // Range edges and aliasing of rejected writes.
    req(0, 1'b1, 4'hF, 32'h8000_0FFC, 32'hA5A5_A5A5, ns);
    chk("top_wr_err", {31'b0, err[0]}, 32'd0);
    req(0, 1'b0, 4'h0, 32'h8000_0FFC, 32'h0, ns);
    chk("top_rd", rdata[0], 32'hA5A5_A5A5);
    req(0, 1'b0, 4'h0, 32'h7FFF_FFFC, 32'h0, ns);
    chk("below_err", {31'b0, err[0]}, 32'd1);
    chk("below_rdata", rdata[0], 32'd0);
    req(0, 1'b1, 4'hF, 32'h8000_1010, 32'h1234_5678, ns);
    chk("above_wr_err", {31'b0, err[0]}, 32'd1);
    req(0, 1'b1, 4'hF, 32'h7FFF_FFFC, 32'h0000_0000, ns);
    req(0, 1'b0, 4'h0, 32'h8000_1000, 32'h0, ns);
    chk("above_rd_err", {31'b0, err[0]}, 32'd1);
    chk("above_rd_rdata", rdata[0], 32'd0);
    req(0, 1'b0, 4'h0, 32'h8000_0010, 32'h0, ns);
    chk("no_alias_hi", rdata[0], 32'hDEAD_BEEF);
    chk("err_cleared", {31'b0, err[0]}, 32'd0);
    req(0, 1'b0, 4'h0, 32'h8000_0FFC, 32'h0, ns);
    chk("no_alias_lo", rdata[0], 32'hA5A5_A5A5);

    // Fixed three-cycle wait instance.
    req(1, 1'b1, 4'hF, 32'h8000_0004, 32'hCAFE_F00D, ns);
    chk("w3_wr_stall", 32'(ns), 32'd3);
    req(1, 1'b0, 4'h0, 32'h8000_0004, 32'h0, ns);
    chk("w3_rd_stall", 32'(ns), 32'd3);
    chk("w3_rd_data", rdata[1], 32'hCAFE_F00D);
    @(negedge clk);
    wen = 1'b0; addr = 32'h8000_0004; cen[1] = 1'b1;
    #1;
    chk("abort_stall", {31'b0, stall[1]}, 32'd1);
    repeat (2) @(negedge clk);
    cen[1] = 1'b0;
    req(1, 1'b0, 4'h0, 32'h8000_0004, 32'h0, ns);
    chk("abort_restall", 32'(ns), 32'd3);
    chk("abort_data", rdata[1], 32'hCAFE_F00D);

    // Reset during a stalled write: outputs clear, write never lands.
    @(negedge clk);
    wen = 1'b1; strb = 4'hF; addr = 32'h8000_0004; wdata = 32'h5555_5555; cen[1] = 1'b1;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rdata", rdata[1], 32'd0);
    chk("midrst_err", {31'b0, err[1]}, 32'd0);
    cen[1] = 1'b0;
    #1;
    chk("midrst_stall", {31'b0, stall[1]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req(1, 1'b0, 4'h0, 32'h8000_0004, 32'h0, ns);
    chk("midrst_wr_dropped", rdata[1], 32'hCAFE_F00D);
    chk("midrst_post_stall", 32'(ns), 32'd3);

    // Random-wait instance against the LFSR model and a shadow memory.
    lf = 16'hACE1;
    tgt = lf[3:0];
    start_acc = acc_cnt;
    for (int i = 0; i < 216; i++) begin
      int          k;
      logic        w;
      logic [3:0]  sb;
      logic [31:0] d;
      k  = (i < 16) ? i : int'($urandom_range(15, 0));
      w  = (i < 16) ? 1'b1 : 1'($urandom_range(1, 0));
      sb = (i < 16) ? 4'hF : 4'($urandom_range(15, 0));
      d  = $urandom;
      req(2, w, sb, 32'h8000_0100 + 32'(k) * 4, d, ns);
      chk("rnd_stall", 32'(ns), {28'b0, tgt});
      if (w) begin
        for (int b = 0; b < 4; b++) begin
          if (sb[b]) shadow[k][8*b +: 8] = d[8*b +: 8];
        end
      end else begin
        chk("rnd_rdata", rdata[2], shadow[k]);
      end
      lf  = ref_lfsr(lf);
      tgt = lf[3:0];
    end
    chk("rnd_acc_count", 32'(acc_cnt - start_acc), 32'd216);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
